// File: rtl/cpu_fwd_pkg.sv
// rtl/cpu_fwd_pkg.sv - shared defaults, source enum and x0 helper for the forwarding unit
//
// Purpose: types and constants shared by fwd_port_mux and fwd_scoreboard_unit.
// Contents:
//   XLEN_DEF / NREG_DEF / RW_DEF  default datapath width, register count, index width
//   fwd_src_e                     where an EX operand comes from
//   is_x0()                       true for the hard-wired zero register
package cpu_fwd_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int RW_DEF   = $clog2(NREG_DEF);

  typedef enum logic [1:0] {
    SRC_ZERO    = 2'd0,
    SRC_STAGE   = 2'd1,
    SRC_LATDONE = 2'd2,
    SRC_RF      = 2'd3
  } fwd_src_e;

  // Indices are zero-extended to 16 bits by the caller so one helper serves any RW.
  function automatic logic is_x0(input logic [15:0] idx);
    return (idx == 16'd0);
  endfunction

endpackage

// File: rtl/fwd_port_mux.sv
// rtl/fwd_port_mux.sv - priority operand select and unready flag for one EX read port
//
// Purpose: picks one EX operand from x0, the forwarding stages (youngest first),
// the returning long-latency result, or the register file, and flags when the
// chosen value is not yet usable.
// Ports:
//   valid          EX holds a real instruction
//   rs             source register index
//   rdata          register-file data for this port
//   fwd_we/rd/ready/data  per-stage forwarding bus, stage 0 youngest
//   lat_done/lat_done_rd/lat_done_data  long-latency return this cycle
//   pending        scoreboard vector
//   op             selected operand
//   unready        this port requires a stall
module fwd_port_mux
  import cpu_fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFS  = 2,
  parameter int RW   = $clog2(NREG)
) (
  input  logic                 valid,
  input  logic [RW-1:0]        rs,
  input  logic [XLEN-1:0]      rdata,
  input  logic [NFS-1:0]       fwd_we,
  input  logic [NFS*RW-1:0]    fwd_rd,
  input  logic [NFS-1:0]       fwd_ready,
  input  logic [NFS*XLEN-1:0]  fwd_data,
  input  logic                 lat_done,
  input  logic [RW-1:0]        lat_done_rd,
  input  logic [XLEN-1:0]      lat_done_data,
  input  logic [NREG-1:0]      pending,
  output logic [XLEN-1:0]      op,
  output logic                 unready
);

  fwd_src_e          src;
  logic [XLEN-1:0]   stage_data;
  logic              stage_ready;
  logic              done_hit;

  assign done_hit = lat_done && (lat_done_rd == rs);

  always_comb begin
    src         = SRC_RF;
    stage_data  = '0;
    stage_ready = 1'b1;
    if (is_x0(16'(rs))) begin
      src = SRC_ZERO;
    end else begin
      // Walk oldest to youngest so the youngest match is the last one assigned.
      // rs != 0 here, so a match also implies rd != 0.
      for (int s = NFS - 1; s >= 0; s--) begin
        if (fwd_we[s] && (fwd_rd[s*RW +: RW] == rs)) begin
          src         = SRC_STAGE;
          stage_data  = fwd_data[s*XLEN +: XLEN];
          stage_ready = fwd_ready[s];
        end
      end
      if ((src != SRC_STAGE) && done_hit) begin
        src = SRC_LATDONE;
      end
    end
  end

  always_comb begin
    case (src)
      SRC_ZERO:    op = '0;
      SRC_STAGE:   op = stage_data;
      SRC_LATDONE: op = lat_done_data;
      default:     op = rdata;
    endcase
  end

  // The youngest matching stage decides readiness: an older ready copy is stale.
  // A pending long-latency write stalls unless its result returns this cycle.
  assign unready = valid && (src != SRC_ZERO) &&
                   (((src == SRC_STAGE) && !stage_ready) || (pending[rs] && !done_hit));

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// rtl/fwd_scoreboard_unit.sv - EX operand forwarding, long-latency scoreboard and stall counter
//
// Purpose: forwards EX operands for NRP read ports over NFS stages, tracks
// long-latency writers in a register scoreboard, raises stall and counts stalls.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid_i/rs_i/rdata_i  EX instruction and its register-file operands
//   fwd_we/rd/ready/data_i   forwarding bus, stage 0 youngest
//   lat_issue_i/rd_i         long-latency op leaving EX
//   lat_done_i/rd_i/data_i   long-latency result returning
//   ex_op_o                  forwarded operands
//   stall_o                  hold ID/EX and earlier
//   issue_ok_o               no WAW against a pending destination
//   pending_o                scoreboard vector
//   stall_cnt_o              saturating stall-cycle count
//   sb_err_o                 sticky: return for a non-pending register
module fwd_scoreboard_unit
  import cpu_fwd_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NRP   = 2,
  parameter int NFS   = 2,
  parameter int CNT_W = 32,
  parameter int RW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid_i,
  input  logic [NRP*RW-1:0]    ex_rs_i,
  input  logic [NRP*XLEN-1:0]  ex_rdata_i,
  input  logic [NFS-1:0]       fwd_we_i,
  input  logic [NFS*RW-1:0]    fwd_rd_i,
  input  logic [NFS-1:0]       fwd_ready_i,
  input  logic [NFS*XLEN-1:0]  fwd_data_i,
  input  logic                 lat_issue_i,
  input  logic [RW-1:0]        lat_issue_rd_i,
  input  logic                 lat_done_i,
  input  logic [RW-1:0]        lat_done_rd_i,
  input  logic [XLEN-1:0]      lat_done_data_i,
  output logic [NRP*XLEN-1:0]  ex_op_o,
  output logic                 stall_o,
  output logic                 issue_ok_o,
  output logic [NREG-1:0]      pending_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic                 sb_err_o
);

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic [NRP-1:0]   port_unready;
  logic [CNT_W-1:0] stall_cnt;
  logic             sb_err;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    fwd_port_mux #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NFS  (NFS),
      .RW   (RW)
    ) u_mux (
      .valid         (ex_valid_i),
      .rs            (ex_rs_i[p*RW +: RW]),
      .rdata         (ex_rdata_i[p*XLEN +: XLEN]),
      .fwd_we        (fwd_we_i),
      .fwd_rd        (fwd_rd_i),
      .fwd_ready     (fwd_ready_i),
      .fwd_data      (fwd_data_i),
      .lat_done      (lat_done_i),
      .lat_done_rd   (lat_done_rd_i),
      .lat_done_data (lat_done_data_i),
      .pending       (pending),
      .op            (ex_op_o[p*XLEN +: XLEN]),
      .unready       (port_unready[p])
    );
  end

  assign stall_o = |port_unready;

  // A return in the same cycle frees the destination, so a new owner may issue.
  assign issue_ok_o = is_x0(16'(lat_issue_rd_i)) || !pending[lat_issue_rd_i] ||
                      (lat_done_i && (lat_done_rd_i == lat_issue_rd_i));

  always_comb begin
    pending_nxt = pending;
    if (lat_done_i) begin
      pending_nxt[lat_done_rd_i] = 1'b0;
    end
    // Applied after the clear so a same-register issue becomes the new owner.
    if (lat_issue_i && issue_ok_o && !is_x0(16'(lat_issue_rd_i))) begin
      pending_nxt[lat_issue_rd_i] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      stall_cnt <= '0;
      sb_err    <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (stall_o && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (lat_done_i && !pending[lat_done_rd_i] && !is_x0(16'(lat_done_rd_i))) begin
        sb_err <= 1'b1;
      end
    end
  end

  assign pending_o   = pending;
  assign stall_cnt_o = stall_cnt;
  assign sb_err_o    = sb_err;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// tb/tb_fwd_scoreboard_unit.sv - scoreboard-queue bench for fwd_scoreboard_unit
module tb_fwd_scoreboard_unit;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NRP   = 2;
  localparam int NFS   = 2;
  localparam int CNT_W = 4;
  localparam int RW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ex_valid_i;
  logic [NRP*RW-1:0]    ex_rs_i;
  logic [NRP*XLEN-1:0]  ex_rdata_i;
  logic [NFS-1:0]       fwd_we_i;
  logic [NFS*RW-1:0]    fwd_rd_i;
  logic [NFS-1:0]       fwd_ready_i;
  logic [NFS*XLEN-1:0]  fwd_data_i;
  logic                 lat_issue_i;
  logic [RW-1:0]        lat_issue_rd_i;
  logic                 lat_done_i;
  logic [RW-1:0]        lat_done_rd_i;
  logic [XLEN-1:0]      lat_done_data_i;
  logic [NRP*XLEN-1:0]  ex_op_o;
  logic                 stall_o;
  logic                 issue_ok_o;
  logic [NREG-1:0]      pending_o;
  logic [CNT_W-1:0]     stall_cnt_o;
  logic                 sb_err_o;

  fwd_scoreboard_unit #(
    .XLEN (XLEN), .NREG (NREG), .NRP (NRP), .NFS (NFS), .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid_i),
    .ex_rs_i         (ex_rs_i),
    .ex_rdata_i      (ex_rdata_i),
    .fwd_we_i        (fwd_we_i),
    .fwd_rd_i        (fwd_rd_i),
    .fwd_ready_i     (fwd_ready_i),
    .fwd_data_i      (fwd_data_i),
    .lat_issue_i     (lat_issue_i),
    .lat_issue_rd_i  (lat_issue_rd_i),
    .lat_done_i      (lat_done_i),
    .lat_done_rd_i   (lat_done_rd_i),
    .lat_done_data_i (lat_done_data_i),
    .ex_op_o         (ex_op_o),
    .stall_o         (stall_o),
    .issue_ok_o      (issue_ok_o),
    .pending_o       (pending_o),
    .stall_cnt_o     (stall_cnt_o),
    .sb_err_o        (sb_err_o)
  );

  always #5 clk = ~clk;

  typedef enum int {K_OP0, K_OP1, K_STALL, K_OK, K_PEND, K_CNT, K_ERR} kind_e;
  typedef struct {
    kind_e       k;
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model of the registered state.
  logic [NREG-1:0]  m_pend  = '0;
  logic [CNT_W-1:0] m_cnt   = '0;
  logic             m_err   = 1'b0;
  logic             m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input kind_e k, input string tag, input logic [31:0] v);
    exp_t e;
    e.k = k; e.tag = tag; e.v = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.k)
        K_OP0:   obs = ex_op_o[0 +: XLEN];
        K_OP1:   obs = ex_op_o[XLEN +: XLEN];
        K_STALL: obs = 32'(stall_o);
        K_OK:    obs = 32'(issue_ok_o);
        K_PEND:  obs = 32'(pending_o);
        K_CNT:   obs = 32'(stall_cnt_o);
        default: obs = 32'(sb_err_o);
      endcase
      check(e.tag, obs, e.v);
    end
  endtask

  task automatic idle();
    ex_valid_i = 1'b0; ex_rs_i = '0; ex_rdata_i = '0;
    fwd_we_i = '0; fwd_rd_i = '0; fwd_ready_i = '1; fwd_data_i = '0;
    lat_issue_i = 1'b0; lat_issue_rd_i = '0;
    lat_done_i = 1'b0; lat_done_rd_i = '0; lat_done_data_i = '0;
  endtask

  task automatic set_port(input int p, input logic [RW-1:0] rs, input logic [XLEN-1:0] d);
    ex_rs_i[p*RW +: RW]       = rs;
    ex_rdata_i[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_stage(input int s, input logic we, input logic [RW-1:0] rd,
                           input logic rdy, input logic [XLEN-1:0] d);
    fwd_we_i[s]              = we;
    fwd_rd_i[s*RW +: RW]     = rd;
    fwd_ready_i[s]           = rdy;
    fwd_data_i[s*XLEN +: XLEN] = d;
  endtask

  // One clock: check combinational expectations and model state at the negedge,
  // then advance the model alongside the DUT at the posedge.
  task automatic cycle(input string tag, input logic exp_stall);
    logic            m_ok;
    logic [NREG-1:0] nxt;
    m_ok = (lat_issue_rd_i == 0) || !m_pend[lat_issue_rd_i] ||
           (lat_done_i && (lat_done_rd_i == lat_issue_rd_i));
    push(K_STALL, {tag, ".stall"}, 32'(exp_stall));
    push(K_OK, {tag, ".issue_ok"}, 32'(m_ok));
    if (m_known) begin
      push(K_PEND, {tag, ".pending"}, 32'(m_pend));
      push(K_CNT, {tag, ".cnt"}, 32'(m_cnt));
      push(K_ERR, {tag, ".err"}, 32'(m_err));
    end
    @(negedge clk);
    drain();
    nxt = m_pend;
    if (lat_done_i) nxt[lat_done_rd_i] = 1'b0;
    if (lat_issue_i && m_ok && lat_issue_rd_i != 0) nxt[lat_issue_rd_i] = 1'b1;
    if (rst) begin
      m_pend = '0; m_cnt = '0; m_err = 1'b0; m_known = 1'b1;
    end else begin
      if (lat_done_i && !m_pend[lat_done_rd_i] && lat_done_rd_i != 0) m_err = 1'b1;
      if (exp_stall && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      m_pend = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cycle("rst", 1'b0);
    rst = 1'b0;

    // Reset state: no matches, operands pass straight from the register file.
    ex_valid_i = 1'b1;
    set_port(0, 5'd1, 32'h1111_1111);
    set_port(1, 5'd2, 32'h2222_2222);
    push(K_OP0, "rst.op0", 32'h1111_1111);
    push(K_OP1, "rst.op1", 32'h2222_2222);
    push(K_PEND, "rst.pend0", 32'h0);
    cycle("rst_out", 1'b0);

    // 1) both stages match rs1=5: youngest wins.
    set_port(0, 5'd5, 32'h5555_0000);
    set_port(1, 5'd6, 32'h6666_0000);
    set_stage(0, 1'b1, 5'd5, 1'b1, 32'hA);
    set_stage(1, 1'b1, 5'd5, 1'b1, 32'hB);
    push(K_OP0, "t1.op0", 32'hA);
    push(K_OP1, "t1.op1", 32'h6666_0000);
    cycle("t1", 1'b0);
    // Only the older stage matches port 1.
    set_stage(0, 1'b1, 5'd8, 1'b1, 32'hA);
    set_stage(1, 1'b1, 5'd6, 1'b1, 32'hB);
    push(K_OP0, "t1b.op0", 32'h5555_0000);
    push(K_OP1, "t1b.op1", 32'hB);
    cycle("t1b", 1'b0);

    // 2) load-use on rs2=7.
    idle();
    ex_valid_i = 1'b1;
    set_port(0, 5'd1, 32'h1);
    set_port(1, 5'd7, 32'h7777);
    set_stage(0, 1'b1, 5'd7, 1'b0, 32'h77);
    cycle("t2a", 1'b1);
    cycle("t2b", 1'b1);
    // Older stage ready for rd 7 does not hide the unready youngest match.
    set_stage(1, 1'b1, 5'd7, 1'b1, 32'h99);
    cycle("t2c", 1'b1);
    set_stage(0, 1'b1, 5'd7, 1'b1, 32'h77);
    push(K_OP1, "t2d.op1", 32'h77);
    cycle("t2d", 1'b0);

    // 3) long-latency producer for x9.
    idle();
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd9;
    cycle("t3_issue", 1'b0);
    idle();
    set_port(0, 5'd9, 32'h9999);
    cycle("t3_novalid", 1'b0);
    ex_valid_i = 1'b1;
    push(K_PEND, "t3.pend9", 32'h200);
    cycle("t3_wait1", 1'b1);
    cycle("t3_wait2", 1'b1);
    lat_done_i = 1'b1; lat_done_rd_i = 5'd9; lat_done_data_i = 32'h55;
    push(K_OP0, "t3.op0_done", 32'h55);
    cycle("t3_done", 1'b0);
    idle();
    push(K_PEND, "t3.pend_clear", 32'h0);
    cycle("t3_after", 1'b0);

    // 4) same-cycle return and reissue of x3.
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd3;
    cycle("t4_issue", 1'b0);
    push(K_OK, "t4.waw_block", 32'h0);
    cycle("t4_waw", 1'b0);
    lat_done_i = 1'b1; lat_done_rd_i = 5'd3; lat_done_data_i = 32'h33;
    push(K_OK, "t4.swap_ok", 32'h1);
    cycle("t4_swap", 1'b0);
    idle();
    push(K_PEND, "t4.pend3", 32'h8);
    lat_done_i = 1'b1; lat_done_rd_i = 5'd3;
    cycle("t4_drain", 1'b0);
    idle();
    cycle("t4_after", 1'b0);

    // 5) x0 never forwards or stalls; stray return sets the sticky error.
    ex_valid_i = 1'b1;
    set_port(0, 5'd0, 32'hFFFF_FFFF);
    set_stage(0, 1'b1, 5'd0, 1'b0, 32'hDEAD);
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd0;
    push(K_OP0, "t5.op0_x0", 32'h0);
    cycle("t5_x0", 1'b0);
    idle();
    lat_done_i = 1'b1; lat_done_rd_i = 5'd4; lat_done_data_i = 32'h44;
    cycle("t5_stray", 1'b0);
    idle();
    push(K_ERR, "t5.err_set", 32'h1);
    cycle("t5_err1", 1'b0);
    cycle("t5_err2", 1'b0);

    // 6) counter saturation, then reset.
    ex_valid_i = 1'b1;
    set_port(0, 5'd7, 32'h0);
    set_stage(0, 1'b1, 5'd7, 1'b0, 32'h77);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle("t6_stall", 1'b1);
    push(K_CNT, "t6.cnt_sat", 32'hF);
    rst = 1'b1;
    cycle("t6_rst", 1'b1);
    rst = 1'b0;
    idle();
    push(K_CNT, "t6.cnt_reset", 32'h0);
    push(K_ERR, "t6.err_reset", 32'h0);
    push(K_PEND, "t6.pend_reset", 32'h0);
    cycle("t6_after", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
